// File: rtl/cycle_seq_pkg.sv
// Shared definitions for the cycle sequencer: state encoding, default
// parameter values and the phase timer width.
package cycle_seq_pkg;

    typedef enum logic [1:0] {
        HALT = 2'b00,
        PX   = 2'b01,
        PY   = 2'b10,
        PZ   = 2'b11
    } seq_state_t;

    localparam int PHASE_LEN_DEFAULT = 2;
    localparam int COUNT_W_DEFAULT   = 16;

    // Wide enough for the largest legal phase length (15).
    localparam int TIMER_W = 4;

endpackage

// File: rtl/cycle_sequencer_phase_timer.sv
// Phase timer: counts 0..PHASE_LEN-1 inside one phase. Clear restarts the
// count at phase entry, hold freezes it, terminal flags the last clock.
module phase_timer
    import cycle_seq_pkg::*;
#(
    parameter int PHASE_LEN = PHASE_LEN_DEFAULT
) (
    input  logic i_CLOCK,
    input  logic i_RESET_N,
    input  logic clear,
    input  logic hold,
    output logic terminal
);

    localparam logic [TIMER_W-1:0] LAST = TIMER_W'(PHASE_LEN - 1);

    logic [TIMER_W-1:0] count;

    // Clock counter within the phase; clear has priority over hold.
    always_ff @(posedge i_CLOCK) begin
        if (!i_RESET_N) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (!hold) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + TIMER_W'(1);
            end
        end
    end

    assign terminal = (count == LAST);

endmodule

// File: rtl/cycle_sequencer.sv
// Instruction cycle sequencer: HALT -> PX -> PY -> PZ, each phase lasting
// PHASE_LEN clocks, with stall, free-run and a completed-instruction count.
// Optional single-step support is built when CYCLE_SEQ_STEP_EN is defined;
// otherwise i_STEP is present but ignored.
module cycle_sequencer
    import cycle_seq_pkg::*;
#(
    parameter int PHASE_LEN = PHASE_LEN_DEFAULT,
    parameter int COUNT_W   = COUNT_W_DEFAULT
) (
    input  logic               i_CLOCK,
    input  logic               i_RESET_N,
    input  logic               i_RUN,
    input  logic               i_STEP,
    input  logic               i_STALL,
    output logic               o_CYCLEX,
    output logic               o_CYCLEY,
    output logic               o_CYCLEZ,
    output logic               o_PHASE_START,
    output logic               o_HALTED,
    output logic [COUNT_W-1:0] o_INSTR_COUNT
);

    localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

    seq_state_t state;
    seq_state_t state_nxt;
    logic       phase_enter;
    logic       phase_done;
    logic       instr_done;
    logic       tc;
    logic       go_step;
    logic       step_active;

`ifdef CYCLE_SEQ_STEP_EN
    logic step_flag;
    assign go_step     = i_STEP;
    assign step_active = step_flag;
`else
    logic unused_step;
    assign unused_step = i_STEP;
    assign go_step     = 1'b0;
    assign step_active = 1'b0;
`endif

    // The last clock of a running phase, not stalled, ends that phase.
    assign phase_done = (state != HALT) && tc && !i_STALL;
    assign instr_done = (state == PZ) && phase_done;

    phase_timer #(
        .PHASE_LEN (PHASE_LEN)
    ) u_timer (
        .i_CLOCK   (i_CLOCK),
        .i_RESET_N (i_RESET_N),
        .clear     ((state == HALT) || phase_done),
        .hold      (i_STALL),
        .terminal  (tc)
    );

    // Next-state selection; a stall freezes the current state.
    always_comb begin
        state_nxt   = state;
        phase_enter = 1'b0;
        if (!i_STALL) begin
            case (state)
                HALT: if (i_RUN || go_step) begin
                    state_nxt   = PX;
                    phase_enter = 1'b1;
                end
                PX: if (tc) begin
                    state_nxt   = PY;
                    phase_enter = 1'b1;
                end
                PY: if (tc) begin
                    state_nxt   = PZ;
                    phase_enter = 1'b1;
                end
                PZ: if (tc) begin
                    if (i_RUN && !step_active) begin
                        state_nxt   = PX;
                        phase_enter = 1'b1;
                    end else begin
                        state_nxt = HALT;
                    end
                end
                default: state_nxt = HALT;
            endcase
        end
    end

    // State register with registered phase enables, status and count.
    always_ff @(posedge i_CLOCK) begin
        if (!i_RESET_N) begin
            state         <= HALT;
            o_CYCLEX      <= 1'b0;
            o_CYCLEY      <= 1'b0;
            o_CYCLEZ      <= 1'b0;
            o_PHASE_START <= 1'b0;
            o_HALTED      <= 1'b1;
            o_INSTR_COUNT <= '0;
`ifdef CYCLE_SEQ_STEP_EN
            step_flag     <= 1'b0;
`endif
        end else begin
            state         <= state_nxt;
            o_CYCLEX      <= (state_nxt == PX);
            o_CYCLEY      <= (state_nxt == PY);
            o_CYCLEZ      <= (state_nxt == PZ);
            o_PHASE_START <= phase_enter;
            o_HALTED      <= (state_nxt == HALT);
            if (instr_done) begin
                o_INSTR_COUNT <= o_INSTR_COUNT + COUNT_ONE;
            end
`ifdef CYCLE_SEQ_STEP_EN
            if (!i_STALL) begin
                if (state == HALT) begin
                    step_flag <= go_step && !i_RUN;
                end else if (instr_done) begin
                    step_flag <= 1'b0;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_cycle_sequencer.sv
// Self-checking bench for cycle_sequencer. A position-in-instruction model
// predicts every output each clock; directed sequences pin the model with
// literal expectations. A narrow second instance covers count wrap-around
// and the single-clock phase case.
module tb_cycle_sequencer;

    localparam int L = 2;

`ifdef CYCLE_SEQ_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic        stall = 1'b0;
    logic        cx, cy, cz, ps, halted;
    logic [15:0] cnt;

    logic        rst2_n = 1'b0;
    logic        run2 = 1'b0;
    logic        cx2, cy2, cz2, ps2, halted2;
    logic [3:0]  cnt2;

    int tests = 0;
    int fails = 0;

    // model state
    bit mbusy = 1'b0;
    int mpos  = 0;
    int mcnt  = 0;
    bit mstep = 1'b0;
    bit mstart = 1'b0;

    always #5 clk = ~clk;

    cycle_sequencer #(.PHASE_LEN(L), .COUNT_W(16)) dut (
        .i_CLOCK(clk), .i_RESET_N(rst_n), .i_RUN(run), .i_STEP(step),
        .i_STALL(stall), .o_CYCLEX(cx), .o_CYCLEY(cy), .o_CYCLEZ(cz),
        .o_PHASE_START(ps), .o_HALTED(halted), .o_INSTR_COUNT(cnt)
    );

    cycle_sequencer #(.PHASE_LEN(1), .COUNT_W(4)) dut2 (
        .i_CLOCK(clk), .i_RESET_N(rst2_n), .i_RUN(run2), .i_STEP(1'b0),
        .i_STALL(1'b0), .o_CYCLEX(cx2), .o_CYCLEY(cy2), .o_CYCLEZ(cz2),
        .o_PHASE_START(ps2), .o_HALTED(halted2), .o_INSTR_COUNT(cnt2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One instruction is 3*L clocks; mpos is the clock index inside it.
    function automatic void model_step();
        if (!rst_n) begin
            mbusy = 1'b0; mpos = 0; mcnt = 0; mstep = 1'b0; mstart = 1'b0;
        end else if (stall) begin
            mstart = 1'b0;
        end else if (!mbusy) begin
            if (run || (STEP_EN && step)) begin
                mbusy = 1'b1; mpos = 0; mstep = !run; mstart = 1'b1;
            end else begin
                mstart = 1'b0;
            end
        end else if (mpos == 3*L-1) begin
            mcnt = (mcnt + 1) % 65536;
            if (run && !mstep) begin
                mpos = 0; mstart = 1'b1;
            end else begin
                mbusy = 1'b0; mpos = 0; mstep = 1'b0; mstart = 1'b0;
            end
        end else begin
            mpos++;
            mstart = ((mpos % L) == 0);
        end
    endfunction

    task automatic check_model();
        chk("model_x",     32'(cx),     32'(mbusy && (mpos / L) == 0));
        chk("model_y",     32'(cy),     32'(mbusy && (mpos / L) == 1));
        chk("model_z",     32'(cz),     32'(mbusy && (mpos / L) == 2));
        chk("model_start", 32'(ps),     32'(mstart));
        chk("model_halt",  32'(halted), 32'(!mbusy));
        chk("model_count", 32'(cnt),    32'(mcnt));
    endtask

    // Called at a falling edge: drive, let one rising edge pass, compare.
    task automatic tick(input logic r, input logic rn, input logic sp, input logic sl);
        rst_n = r; run = rn; step = sp; stall = sl;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    initial begin
        logic [5:0] xs, ys, zs, ss;
        int ycount;
        logic st_seen;
        logic r_run;

        @(negedge clk);

        // Narrow instance: phase start every clock, count wraps 15 -> 0.
        rst2_n = 1'b0; run2 = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("wrap_reset_count", 32'(cnt2), 32'd0);
        chk("wrap_reset_halted", 32'(halted2), 32'd1);
        rst2_n = 1'b1; run2 = 1'b1;
        for (int n = 1; n <= 49; n++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            chk("len1_start", 32'(ps2), 32'd1);
            if (n == 1)  chk("len1_first_x", 32'(cx2), 32'd1);
            if (n == 45) chk("wrap_count_14", 32'(cnt2), 32'd14);
            if (n == 46) chk("wrap_count_15", 32'(cnt2), 32'd15);
            if (n == 49) chk("wrap_count_0", 32'(cnt2), 32'd0);
        end
        run2 = 1'b0;

        // Reset state.
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        chk("rst_x", 32'(cx), 32'd0);
        chk("rst_y", 32'(cy), 32'd0);
        chk("rst_z", 32'(cz), 32'd0);
        chk("rst_start", 32'(ps), 32'd0);
        chk("rst_halted", 32'(halted), 32'd1);
        chk("rst_count", 32'(cnt), 32'd0);

        // Single step pulse, repeated pulse during PY.
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        chk("step_enter_x", 32'(cx), 32'(STEP_EN));
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        chk("step_halted", 32'(halted), 32'd1);
        chk("step_count", 32'(cnt), STEP_EN ? 32'd1 : 32'd0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        chk("step_stays_halted", 32'(halted), 32'd1);

        // Free run from reset: X clocks 1-2, Y 3-4, Z 5-6.
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        for (int t = 0; t < 6; t++) begin
            tick(1'b1, 1'b1, 1'b0, 1'b0);
            xs[t] = cx; ys[t] = cy; zs[t] = cz; ss[t] = ps;
        end
        chk("run_x_pattern", 32'(xs), 32'(6'b000011));
        chk("run_y_pattern", 32'(ys), 32'(6'b001100));
        chk("run_z_pattern", 32'(zs), 32'(6'b110000));
        chk("run_start_pattern", 32'(ss), 32'(6'b010101));
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        chk("run_count_1", 32'(cnt), 32'd1);
        chk("run_next_x", 32'(cx), 32'd1);

        // Run dropped in the first PX clock: instruction completes.
        for (int t = 0; t < 5; t++) tick(1'b1, 1'b0, 1'b0, 1'b0);
        chk("drop_not_yet_halted", 32'(halted), 32'd0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        chk("drop_halted", 32'(halted), 32'd1);
        chk("drop_count_2", 32'(cnt), 32'd2);

        // Three stall clocks during PY stretch Y to five clocks.
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        ycount = 0; st_seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick(1'b1, (k <= 3), 1'b0, (k >= 1 && k <= 3));
            if (cy) ycount++;
            if (k >= 1 && k <= 3) st_seen = st_seen | ps;
        end
        chk("stall_y_clocks", 32'(ycount), 32'd5);
        chk("stall_start_low", 32'(st_seen), 32'd0);
        chk("stall_halted", 32'(halted), 32'd1);
        chk("stall_count_3", 32'(cnt), 32'd3);

        // Reset during PZ aborts the instruction.
        for (int t = 0; t < 5; t++) tick(1'b1, 1'b1, 1'b0, 1'b0);
        chk("pz_reached", 32'(cz), 32'd1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        chk("pzrst_z", 32'(cz), 32'd0);
        chk("pzrst_halted", 32'(halted), 32'd1);
        chk("pzrst_count", 32'(cnt), 32'd0);

        // Randomized traffic against the model.
        r_run = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) r_run = ~r_run;
            tick(($urandom_range(63) != 0), r_run,
                 ($urandom_range(9) == 0), ($urandom_range(4) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cycle_sequencer.md
CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

Interface
REQ-001 SHALL have parameter PHASE_LEN, default 2, clocks per phase (legal 1..15).
REQ-002 SHALL have parameter COUNT_W, default 16, width of the instruction counter.
REQ-003 SHALL have port i_CLOCK  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port i_RESET_N  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port i_RUN  input  1  level; 1 = free-run instruction cycles.
REQ-006 SHALL have port i_STEP  input  1  request one instruction cycle while halted.
REQ-007 SHALL have port i_STALL  input  1  level; 1 = hold the current phase.
REQ-008 SHALL have port o_CYCLEX  output  1  fetch-phase enable.
REQ-009 SHALL have port o_CYCLEY  output  1  decode-phase enable.
REQ-010 SHALL have port o_CYCLEZ  output  1  execute-phase enable.
REQ-011 SHALL have port o_PHASE_START  output  1  high on the first clock of each phase.
REQ-012 SHALL have port o_HALTED  output  1  high while in HALT.
REQ-013 SHALL have port o_INSTR_COUNT  output  COUNT_W  completed instruction cycles.

Function
REQ-014 SHALL implement the states HALT, PX, PY and PZ, with all outputs registered.
REQ-015 In PX, PY and PZ respectively, exactly one of o_CYCLEX, o_CYCLEY and o_CYCLEZ SHALL be high; in HALT all three SHALL be low.
REQ-016 HALT SHALL go to PX on the next edge when i_RUN=1 (one-clock latency); o_PHASE_START SHALL be 1 in that first PX clock.
REQ-017 Each phase SHALL last PHASE_LEN clocks, counted by a phase timer running 0..PHASE_LEN-1 that clears on every phase entry.
REQ-018 With the timer at PHASE_LEN-1 and i_STALL=0, the sequence SHALL advance PX->PY->PZ.
REQ-019 While i_STALL=1, the state, the timer and the phase enables SHALL hold, and o_PHASE_START SHALL be 0.
REQ-020 At the end of PZ, o_INSTR_COUNT SHALL increment, wrapping from 2^COUNT_W-1 to 0.
REQ-021 After the end of PZ, the next state SHALL be PX if i_RUN=1 and no step is active, otherwise HALT.
REQ-022 When i_RUN falls mid-instruction, the current instruction SHALL complete through PZ before the block enters HALT; there is no mid-instruction halt.
REQ-023 When i_STALL=1 in the final PZ clock, the instruction count SHALL not increment until the stall releases and PZ actually ends.
REQ-024 With PHASE_LEN=1, each phase SHALL last exactly one clock and o_PHASE_START SHALL be high every clock outside HALT and stall.

Reset
REQ-025 While i_RESET_N=0 at a clock edge, the block SHALL enter HALT with o_CYCLEX/Y/Z=0, o_PHASE_START=0, o_HALTED=1, o_INSTR_COUNT=0, the timer cleared and the step flag cleared.
REQ-026 A reset asserted mid-phase SHALL abort the instruction without any count increment.
REQ-027 Reset SHALL take priority over i_RUN, i_STEP and i_STALL.

Configuration
REQ-028 With macro CYCLE_SEQ_STEP_EN defined, i_STEP=1 sampled in HALT with i_RUN=0 SHALL set a step flag and start exactly one PX-PY-PZ sequence, then return to HALT regardless of i_RUN.
REQ-029 With CYCLE_SEQ_STEP_EN defined, i_STEP SHALL be ignored outside HALT, and when i_RUN and i_STEP are both 1 in HALT, i_RUN SHALL win.
REQ-030 Without CYCLE_SEQ_STEP_EN, the i_STEP port SHALL still exist but be ignored, and no step flag SHALL be built.

Structure
REQ-031 Package cycle_seq_pkg SHALL hold the state encoding (HALT=2'b00, PX=2'b01, PY=2'b10, PZ=2'b11) and the PHASE_LEN_DEFAULT and COUNT_W_DEFAULT constants.
REQ-032 The phase timer SHALL be one sub-module, phase_timer, with clear, hold and a terminal-count output.

Verification
REQ-033 Reset, then i_RUN=1 with PHASE_LEN=2 -> o_CYCLEX high from clock 1 to 2, o_CYCLEY from clock 3 to 4, o_CYCLEZ from clock 5 to 6, and o_INSTR_COUNT=1 after clock 6.
REQ-034 i_STALL=1 for 3 clocks during PY -> o_CYCLEY held for 5 clocks and o_PHASE_START low throughout the stall.
REQ-035 i_RUN dropped in the first PX clock -> PY and PZ complete, then o_HALTED=1 with the count incremented by 1.
REQ-036 With CYCLE_SEQ_STEP_EN, a one-clock i_STEP pulse in HALT -> one full X/Y/Z sequence, then HALT and count +1; a repeat pulse during PY has no effect.
REQ-037 Preload o_INSTR_COUNT to 16'hFFFF, then complete one instruction -> o_INSTR_COUNT=16'h0000.
REQ-038 i_RESET_N=0 during PZ -> all enables 0, o_HALTED=1 and count 0 on the next edge.
